// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 BCM scanner: scan states, a clog2 helper
// and the bit-plane on-time formula used by both RTL and bench.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT_OE,
    ST_BLANK,
    ST_LATCH
  } scan_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Plane p is lit for base<<p cycles (binary-coded modulation weight).
  function automatic int unsigned bcm_on_cycles(input int unsigned base,
                                                input int unsigned plane);
    return base << plane;
  endfunction

endpackage

// File: rtl/bcm_oe_timer.sv
// Loadable down-counter that times the output-enable window of the lit plane.
// expiring flags the last busy cycle (or an already idle timer).
module bcm_oe_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             expiring
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy     = (count_q != '0);
  assign expiring = (count_q <= WIDTH'(1));

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 scan generator with binary-coded modulation: plane N+1 is shifted in
// while plane N is lit, OE window timed by bcm_oe_timer.
//   state      | meaning
//   ST_IDLE    | stopped, all outputs 0, waits for enable
//   ST_SHIFT   | 2*COLUMNS cycles: load/clock one column per cycle pair
//   ST_WAIT_OE | hold until OE timer expires (also drains last plane on stop)
//   ST_BLANK   | BLANK_CYCLES with OE forced off before the latch
//   ST_LATCH   | one-cycle row latch, promotes shifted row/plane to active
module hub75_bcm_scan
  import hub75_pkg::*;
#(
  parameter int unsigned COLUMNS         = 64,
  parameter int unsigned ROW_ADDR_WIDTH  = 4,
  parameter int unsigned BRIGHTNESS_BITS = 6,
  parameter int unsigned BLANK_CYCLES    = 2,
  parameter int unsigned BASE_OE_CYCLES  = 1
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [BRIGHTNESS_BITS-1:0]     brightness_enable,
  output logic [clog2(COLUMNS)-1:0]      column_address,
  output logic [ROW_ADDR_WIDTH-1:0]      row_address,
  output logic [ROW_ADDR_WIDTH-1:0]      row_address_active,
  output logic [BRIGHTNESS_BITS-1:0]     brightness_mask,
  output logic                           pixel_load,
  output logic                           clk_pixel,
  output logic                           row_latch,
  output logic                           output_enable,
  output logic                           frame_start
);

  localparam int unsigned COL_W   = clog2(COLUMNS);
  localparam int unsigned CNT_W   = clog2(2 * COLUMNS + BLANK_CYCLES);
  localparam int unsigned PLANE_W = (clog2(BRIGHTNESS_BITS) > 0) ? clog2(BRIGHTNESS_BITS) : 1;
  localparam int unsigned TMR_W   = clog2(BASE_OE_CYCLES) + BRIGHTNESS_BITS + 1;

  scan_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ROW_ADDR_WIDTH-1:0] row_q, row_d;
  logic [PLANE_W-1:0]        plane_q, plane_d;
  logic [ROW_ADDR_WIDTH-1:0] row_act_q, row_act_d;
  logic [PLANE_W-1:0]        plane_act_q, plane_act_d;
  logic                      drain_q, drain_d;
  logic                      tmr_load, tmr_busy, tmr_expiring;
  logic [TMR_W-1:0]          tmr_value;

  assign tmr_value = TMR_W'(bcm_on_cycles(BASE_OE_CYCLES, 32'(plane_q)));

  bcm_oe_timer #(.WIDTH(TMR_W)) u_oe_timer (
    .clk_in   (clk_in),
    .reset    (reset),
    .load     (tmr_load),
    .value    (tmr_value),
    .busy     (tmr_busy),
    .expiring (tmr_expiring)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    plane_d     = plane_q;
    row_act_d   = row_act_q;
    plane_act_d = plane_act_q;
    drain_d     = drain_q;
    tmr_load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(2 * COLUMNS - 1)) begin
          state_d = ST_WAIT_OE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_OE: begin
        if (tmr_expiring) begin
          if (drain_q) begin
            state_d     = ST_IDLE;
            drain_d     = 1'b0;
            row_act_d   = '0;
            plane_act_d = '0;
          end else begin
            state_d = ST_BLANK;
          end
        end
      end
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LATCH: begin
        tmr_load    = 1'b1;
        row_act_d   = row_q;
        plane_act_d = plane_q;
        state_d     = ST_SHIFT;
        if (plane_q == PLANE_W'(BRIGHTNESS_BITS - 1)) begin
          plane_d = '0;
          row_d   = row_q + ROW_ADDR_WIDTH'(1);
          // Frame boundary: stopping still lets the last plane burn its full window.
          if ((row_q == '1) && !enable) begin
            state_d = ST_WAIT_OE;
            drain_d = 1'b1;
          end
        end else begin
          plane_d = plane_q + PLANE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      plane_q     <= '0;
      row_act_q   <= '0;
      plane_act_q <= '0;
      drain_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      plane_q     <= plane_d;
      row_act_q   <= row_act_d;
      plane_act_q <= plane_act_d;
      drain_q     <= drain_d;
    end
  end

  assign column_address     = (state_q == ST_SHIFT) ? cnt_q[COL_W:1] : '0;
  assign pixel_load         = (state_q == ST_SHIFT) && !cnt_q[0];
  assign clk_pixel          = (state_q == ST_SHIFT) && cnt_q[0];
  assign brightness_mask    = (state_q == ST_SHIFT) ? (BRIGHTNESS_BITS'(1) << plane_q) : '0;
  assign row_latch          = (state_q == ST_LATCH);
  assign output_enable      = tmr_busy && brightness_enable[plane_act_q];
  assign frame_start        = (state_q == ST_SHIFT) && (cnt_q == '0) &&
                              (row_q == '0) && (plane_q == '0);
  assign row_address        = row_q;
  assign row_address_active = row_act_q;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Bench for hub75_bcm_scan: cycle-level timeline model of the small config plus
// literal checks, and a second instance with long BCM weights.
module tb_hub75_bcm_scan;
  import hub75_pkg::*;

  localparam int C = 4, RAW = 1, BB = 2, BLK = 2, BASE = 1, ROWS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a;
  logic [1:0] be_a;
  logic [1:0] col_a, mask_a;
  logic       ra_a, raa_a, pl_a, cp_a, rl_a, oe_a, fs_a;
  logic [10:0] outs_a;
  assign outs_a = {col_a, ra_a, raa_a, mask_a, pl_a, cp_a, rl_a, oe_a, fs_a};

  logic       rst_b, en_b;
  logic [5:0] be_b, mask_b;
  logic [1:0] col_b;
  logic       ra_b, raa_b, pl_b, cp_b, rl_b, oe_b, fs_b;

  hub75_bcm_scan #(.COLUMNS(C), .ROW_ADDR_WIDTH(RAW), .BRIGHTNESS_BITS(BB),
                   .BLANK_CYCLES(BLK), .BASE_OE_CYCLES(BASE)) dut_a (
    .clk_in(clk), .reset(rst_a), .enable(en_a), .brightness_enable(be_a),
    .column_address(col_a), .row_address(ra_a), .row_address_active(raa_a),
    .brightness_mask(mask_a), .pixel_load(pl_a), .clk_pixel(cp_a),
    .row_latch(rl_a), .output_enable(oe_a), .frame_start(fs_a));

  hub75_bcm_scan #(.COLUMNS(4), .ROW_ADDR_WIDTH(1), .BRIGHTNESS_BITS(6),
                   .BLANK_CYCLES(2), .BASE_OE_CYCLES(8)) dut_b (
    .clk_in(clk), .reset(rst_b), .enable(en_b), .brightness_enable(be_b),
    .column_address(col_b), .row_address(ra_b), .row_address_active(raa_b),
    .brightness_mask(mask_b), .pixel_load(pl_b), .clk_pixel(cp_b),
    .row_latch(rl_b), .output_enable(oe_b), .frame_start(fs_b));

  int checks = 0, fails = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Timeline model: a slot per shifted plane, OE window as an absolute cycle range.
  typedef enum int {M_IDLE, M_RUN, M_DRAIN} mmode_e;
  mmode_e m_mode = M_IDLE;
  int cyc = 0;
  int m_start = 0, m_period = 0, m_row = 0, m_plane = 0;
  int m_act_row = 0, m_act_plane = 0, m_lat = 0, m_T = 0;
  bit m_win = 0;

  bit rec = 0, win_on = 0, drop_mon = 0, prev_latch = 0;
  int fs_q[$], lat_q[$], pl_cols[$], pl_cyc[$], act_q[$], oe_runs[$];
  int oe_len = 0, win_oe = 0, win_lat = 0, fs_after = 0;

  always @(negedge clk) begin : model_a
    logic [10:0] exp_v;
    logic [1:0]  e_col, e_mask;
    logic        e_pl, e_cp, e_rl, e_oe, e_fs;
    int          o, slack;
    bit          wrap;
    if (!rst_a) begin
      m_mode = M_IDLE; m_row = 0; m_plane = 0;
      m_act_row = 0; m_act_plane = 0; m_win = 0;
    end
    e_col = 2'd0; e_mask = 2'd0; e_pl = 0; e_cp = 0; e_rl = 0; e_fs = 0;
    o = cyc - m_start;
    if (m_mode == M_RUN) begin
      if (o < 2 * C) begin
        e_pl   = (o % 2 == 0);
        e_cp   = (o % 2 == 1);
        e_col  = 2'(o / 2);
        e_mask = 2'(1 << m_plane);
        e_fs   = (o == 0) && (m_row == 0) && (m_plane == 0);
      end
      if (o == m_period - 1) e_rl = 1;
    end
    e_oe  = m_win && (cyc > m_lat) && (cyc <= m_lat + m_T) && be_a[m_act_plane];
    exp_v = {e_col, 1'(m_row), 1'(m_act_row), e_mask, e_pl, e_cp, e_rl, e_oe, e_fs};
    checks++;
    if (outs_a !== exp_v) begin
      fails++;
      $display("FAIL cycle_compare cyc=%0d got=%b expected=%b", cyc, outs_a, exp_v);
    end

    if (rec) begin
      if (fs_a) fs_q.push_back(cyc);
      if (rl_a) lat_q.push_back(cyc);
      if (pl_a && pl_cols.size() < 4) begin
        pl_cols.push_back(int'(col_a));
        pl_cyc.push_back(cyc);
      end
      if (prev_latch) act_q.push_back(int'(raa_a));
    end
    prev_latch = rl_a;
    if (oe_a) oe_len++;
    else if (oe_len > 0) begin oe_runs.push_back(oe_len); oe_len = 0; end
    if (win_on) begin win_oe += int'(oe_a); win_lat += int'(rl_a); end
    if (drop_mon && fs_a) fs_after++;

    if (rst_a) begin
      case (m_mode)
        M_IDLE: if (en_a) begin
          m_mode = M_RUN; m_start = cyc + 1; m_row = 0; m_plane = 0;
          m_period = 2 * C + 1 + BLK + 1;
        end
        M_RUN: if (o == m_period - 1) begin
          m_lat = cyc; m_T = int'(bcm_on_cycles(BASE, m_plane)); m_win = 1;
          m_act_row = m_row; m_act_plane = m_plane;
          wrap = (m_plane == BB - 1) && (m_row == ROWS - 1);
          if (m_plane == BB - 1) begin m_plane = 0; m_row = (m_row + 1) % ROWS; end
          else m_plane++;
          if (wrap && !en_a) m_mode = M_DRAIN;
          else begin
            slack = (m_T - 2 * C > 1) ? m_T - 2 * C : 1;
            m_start = cyc + 1; m_period = 2 * C + slack + BLK + 1;
          end
        end
        M_DRAIN: if (cyc == m_lat + m_T) begin
          m_mode = M_IDLE; m_act_row = 0; m_act_plane = 0; m_win = 0;
        end
        default: m_mode = M_IDLE;
      endcase
    end
    cyc++;
  end

  // Second instance: record OE run widths, latch times and last-clk-to-latch gaps.
  int b_cyc = 0, b_oe_len = 0, b_last_cp = 0;
  int b_runs[$], b_lat[$], b_gap[$];
  always @(negedge clk) begin : mon_b
    if (cp_b) b_last_cp = b_cyc;
    if (rl_b && b_lat.size() < 16) begin
      b_lat.push_back(b_cyc);
      b_gap.push_back(b_cyc - b_last_cp);
    end
    if (oe_b) b_oe_len++;
    else if (b_oe_len > 0) begin
      if (b_runs.size() < 16) b_runs.push_back(b_oe_len);
      b_oe_len = 0;
    end
    b_cyc++;
  end

  initial begin
    int en_cyc;
    bit found;
    int exp_oe[4]  = '{1, 2, 1, 2};
    int exp_act[4] = '{0, 0, 1, 1};
    int exp_b[6]   = '{8, 16, 32, 64, 128, 256};

    rst_a = 0; en_a = 0; be_a = 2'b11;
    rst_b = 0; en_b = 1; be_b = 6'h3f;
    repeat (3) @(posedge clk);
    #2 rst_a = 1; rst_b = 1;
    repeat (20) @(posedge clk);
    #2 chk("idle_outputs_zero", int'(outs_a), 0);

    // Directed timeline, all planes enabled.
    oe_runs.delete(); oe_len = 0; rec = 1;
    en_a = 1; en_cyc = cyc;
    repeat (100) @(posedge clk);
    #2 rec = 0;
    if (fs_q.size() < 2 || lat_q.size() < 5 || oe_runs.size() < 4 ||
        act_q.size() < 4 || pl_cols.size() < 4) begin
      chk("directed_event_count", 0, 1);
    end else begin
      chk("start_latency_frame_start", fs_q[0] - en_cyc, 1);
      chk("start_latency_pixel_load", pl_cyc[0] - en_cyc, 1);
      chk("first_latch_offset", lat_q[0] - fs_q[0], 11);
      chk("frame_period", fs_q[1] - fs_q[0], 48);
      for (int i = 0; i < 4; i++) begin
        chk("latch_spacing", lat_q[i + 1] - lat_q[i], 12);
        chk("oe_width", oe_runs[i], exp_oe[i]);
        chk("row_active_seq", act_q[i], exp_act[i]);
        chk("load_column", pl_cols[i], i);
      end
    end

    // Plane 1 disabled: OE only for plane 0, latch cadence unchanged.
    be_a = 2'b01;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (fs_a) begin found = 1; break; end
    end
    chk("wait_frame_start_gated", int'(found), 1);
    win_oe = 0; win_lat = 0; win_on = 1;
    repeat (48) @(negedge clk);
    #1 win_on = 0;
    chk("gated_oe_cycles", win_oe, 2);
    chk("gated_latch_count", win_lat, 4);

    // Drop enable mid-frame.
    be_a = 2'b11;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (fs_a) begin found = 1; break; end
    end
    chk("wait_frame_start_drop", int'(found), 1);
    repeat (20) @(posedge clk);
    #2 en_a = 0; oe_runs.delete(); fs_after = 0; drop_mon = 1;
    repeat (100) @(posedge clk);
    #2 drop_mon = 0;
    chk("no_frame_start_after_drop", fs_after, 0);
    if (oe_runs.size() == 0) chk("drain_oe_seen", 0, 1);
    else chk("drain_last_oe_width", oe_runs[oe_runs.size() - 1], 2);
    chk("stopped_outputs_zero", int'(outs_a), 0);

    // Async reset in the middle of a shift while OE is lit.
    en_a = 1;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (oe_a && (pl_a || cp_a)) begin found = 1; break; end
    end
    chk("wait_oe_during_shift", int'(found), 1);
    #2 rst_a = 0;
    #1 chk("async_reset_clears", int'(outs_a), 0);
    @(posedge clk); @(posedge clk);
    #2 rst_a = 1; en_cyc = cyc;
    @(negedge clk); @(negedge clk); #1;
    chk("restart_after_reset", int'({fs_a, pl_a, ra_a, mask_a}), 5'b11001);

    // Randomised enable / brightness_enable activity against the model.
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 39) == 0) en_a = ~en_a;
      if ($urandom_range(0, 14) == 0) be_a = 2'($urandom);
    end

    // Long-weight instance: plane 5 lit 256 cycles, WAIT_OE stretched to 248.
    if (b_runs.size() < 6 || b_lat.size() < 7) begin
      chk("b_event_count", 0, 1);
    end else begin
      for (int i = 0; i < 6; i++) chk("b_oe_width", b_runs[i], exp_b[i]);
      chk("b_period_plane1", b_lat[1] - b_lat[0], 12);
      chk("b_period_after_plane5", b_lat[6] - b_lat[5], 259);
      chk("b_first_tail", b_gap[0], 4);
      chk("b_wait_oe_tail", b_gap[6], 251);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
